// File: rtl/neuron_feeder.sv
// Feeder for one serial neuron: buffers an N-entry fp32 feature vector, streams it
// one word per clock, waits for the neuron to finish and hands the result to the host.
module neuron_feeder #(
   parameter int N       = 10,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld_valid,
   input  logic [$clog2(N)-1:0] ld_idx,
   input  logic [31:0]          ld_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 nrn_rst,
   output logic [31:0]          nrn_x,
   input  logic [31:0]          nrn_out,
   input  logic                 nrn_done,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_data,
   output logic                 err_timeout
);

   localparam int IW   = $clog2(N);
   localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_SETTLE, S_RESULT
   } state_t;

   state_t          state_q;
   logic [31:0]     feat_q [N];
   logic [IW-1:0]   k_q;
   logic [IW-1:0]   k_d;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            nrn_rst_q;
   logic [31:0]     nrn_x_q;
   logic            res_valid_q;
   logic [31:0]     res_data_q;
   logic            err_q;

   assign k_d         = k_q + 1'b1;
   assign busy        = busy_q;
   assign nrn_rst     = nrn_rst_q;
   assign nrn_x       = nrn_x_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign err_timeout = err_q;

   // nrn_x always shows feat[k_q] during the k-th stream cycle, so the next word
   // is loaded one edge ahead (feat[0] on the CLEAR edge).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         nrn_rst_q   <= 1'b1;
         nrn_x_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < N; i++) feat_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ld_valid && (int'(ld_idx) < N)) feat_q[ld_idx] <= ld_data;
               if (start) begin
                  state_q <= S_CLEAR;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
               end
            end
            S_CLEAR: begin
               state_q   <= S_STREAM;
               k_q       <= '0;
               nrn_rst_q <= 1'b0;
               nrn_x_q   <= feat_q[0];
            end
            S_STREAM: begin
               if (k_q == IW'(N - 1)) begin
                  state_q <= S_WAIT;
                  nrn_x_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  k_q     <= k_d;
                  nrn_x_q <= feat_q[k_d];
               end
            end
            S_WAIT: begin
               if (nrn_done) begin
                  state_q <= S_SETTLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_q   <= S_IDLE;
                  err_q     <= 1'b1;
                  busy_q    <= 1'b0;
                  nrn_rst_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SETTLE: begin
               // Let the MAC/adder pipeline drain before sampling the result.
               if (cnt_q == CW'(SETTLE - 1)) begin
                  state_q     <= S_RESULT;
                  res_data_q  <= nrn_out;
                  res_valid_q <= 1'b1;
                  nrn_rst_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               nrn_rst_q <= 1'b1;
               nrn_x_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder with a small behavioural neuron stub that
// raises nrn_done after the stream and only presents a valid nrn_out once settled.
module tb_neuron_feeder;

   localparam int N       = 10;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ld_valid = 1'b0;
   logic [3:0]  ld_idx = '0;
   logic [31:0] ld_data = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        nrn_rst;
   logic [31:0] nrn_x;
   logic [31:0] nrn_out;
   logic        nrn_done = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        err_timeout;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_vec [N];
   logic [31:0] stub_out = '0;
   logic        done_en  = 1'b1;
   int          scnt     = 0;

   always #5 clk = ~clk;

   neuron_feeder #(.N(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
      .start(start), .busy(busy), .nrn_rst(nrn_rst), .nrn_x(nrn_x), .nrn_out(nrn_out),
      .nrn_done(nrn_done), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .err_timeout(err_timeout)
   );

   // Neuron stub: done one cycle after the N-th sample, output garbage until settled.
   always @(posedge clk) begin
      if (nrn_rst !== 1'b0) begin
         scnt     <= 0;
         nrn_done <= 1'b0;
      end else begin
         scnt <= scnt + 1;
         if (scnt == N && done_en) nrn_done <= 1'b1;
      end
   end
   assign nrn_out = (scnt >= N + 3) ? stub_out : 32'hDEADBEEF;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_all(input logic [31:0] v);
      for (int i = 0; i < N; i++) begin
         ld_valid = 1'b1; ld_idx = 4'(i); ld_data = v;
         exp_vec[i] = v;
         step();
      end
      ld_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic with_ld, input logic [31:0] d);
      start = 1'b1; ld_valid = with_ld; ld_idx = 4'd3; ld_data = d;
      step();
      start = 1'b0; ld_valid = 1'b0;
   endtask

   task automatic do_stream(input string tag, input int poke_k);
      n_tests++;
      if ({busy, nrn_rst, nrn_x} !== {1'b1, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL %s_clear: busy/nrn_rst/nrn_x got %b/%b/%h want 1/1/0", tag, busy, nrn_rst, nrn_x);
      end
      for (int k = 0; k < N; k++) begin
         step();
         start = 1'b0; ld_valid = 1'b0;
         n_tests++;
         if (nrn_x !== exp_vec[k] || nrn_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stream[%0d]: nrn_x got %h want %h, nrn_rst got %b want 0", tag, k, nrn_x, exp_vec[k], nrn_rst);
         end
         if (k == poke_k) begin
            start = 1'b1; ld_valid = 1'b1; ld_idx = 4'd3; ld_data = 32'h40000000;
         end
      end
      step();
      start = 1'b0; ld_valid = 1'b0;
      n_tests++;
      if (nrn_x !== 32'h0 || busy !== 1'b1 || nrn_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_wait: nrn_x/busy/nrn_rst got %h/%b/%b want 0/1/0", tag, nrn_x, busy, nrn_rst);
      end
   endtask

   task automatic finish_run(input string tag, input logic [31:0] want, input logic ready_early);
      int lat;
      lat = 0;
      res_ready = ready_early;
      for (int i = 0; i < 100; i++) begin
         step();
         lat++;
         if (res_valid === 1'b1) break;
      end
      n_tests++;
      if (res_valid !== 1'b1 || lat != 4) begin
         n_fail++;
         $display("FAIL %s_latency: res_valid %b after %0d cycles in WAIT, want 1 after 4", tag, res_valid, lat);
      end
      n_tests++;
      if (res_data !== want || nrn_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_result: res_data got %h want %h, nrn_rst got %b want 1", tag, res_data, want, nrn_rst);
      end
      if (ready_early) begin
         step();
         res_ready = 1'b0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (res_valid !== 1'b1 || res_data !== want) begin
               n_fail++;
               $display("FAIL %s_hold[%0d]: res_valid/res_data got %b/%h want 1/%h", tag, i, res_valid, res_data, want);
            end
         end
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
      end
      n_tests++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_xfer: res_valid/busy got %b/%b want 0/0", tag, res_valid, busy);
      end
      step();
      n_tests++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || nrn_rst !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_idle: res_valid/busy/nrn_rst got %b/%b/%b want 0/0/1", tag, res_valid, busy, nrn_rst);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(); step();
      n_tests++;
      if ({busy, nrn_rst, nrn_x, res_valid, res_data, err_timeout} !== {1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: busy %b nrn_rst %b nrn_x %h res_valid %b res_data %h err %b want 0 1 0 0 0 0",
                  busy, nrn_rst, nrn_x, res_valid, res_data, err_timeout);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_positive();
      load_all(32'h3F800000);
      stub_out = 32'h3FE66666;
      pulse_start(1'b0, 32'h0);
      do_stream("pos", -1);
      finish_run("pos", 32'h3FE66666, 1'b0);
      n_tests++;
      if (err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL pos_err: err_timeout got %b want 0", err_timeout);
      end
   endtask

   task automatic test_negative();
      load_all(32'hBF800000);
      stub_out = 32'h00000000;
      pulse_start(1'b0, 32'h0);
      do_stream("neg", -1);
      finish_run("neg", 32'h00000000, 1'b1);
      n_tests++;
      if (err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL neg_err: err_timeout got %b want 0", err_timeout);
      end
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      done_en = 1'b0;
      pulse_start(1'b0, 32'h0);
      do_stream("to", -1);
      for (int j = 1; j < TIMEOUT; j++) begin
         step();
         if (err_timeout !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL to_early: %0d cycles with err/busy/res_valid wrong before TIMEOUT, want 0", bad);
      end
      step();
      n_tests++;
      if ({err_timeout, busy, res_valid, nrn_rst} !== 4'b1001) begin
         n_fail++;
         $display("FAIL to_fire: err/busy/res_valid/nrn_rst got %b%b%b%b want 1001", err_timeout, busy, res_valid, nrn_rst);
      end
      step(); step();
      n_tests++;
      if (res_valid !== 1'b0 || err_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL to_sticky: res_valid/err got %b/%b want 0/1", res_valid, err_timeout);
      end
      done_en = 1'b1;
      stub_out = 32'h3F000000;
      pulse_start(1'b0, 32'h0);
      n_tests++;
      if (err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_clear: err_timeout got %b want 0", err_timeout);
      end
      do_stream("to2", -1);
      finish_run("to2", 32'h3F000000, 1'b1);
   endtask

   task automatic test_ignore_busy();
      stub_out = 32'h00000000;
      pulse_start(1'b0, 32'h0);
      do_stream("ign", 2);
      finish_run("ign", 32'h00000000, 1'b1);
      pulse_start(1'b0, 32'h0);
      do_stream("ign2", -1);
      finish_run("ign2", 32'h00000000, 1'b1);
      exp_vec[3] = 32'h40000000;
      stub_out = 32'h3F4CCCCD;
      pulse_start(1'b1, 32'h40000000);
      do_stream("same", -1);
      finish_run("same", 32'h3F4CCCCD, 1'b1);
   endtask

   task automatic test_reset_mid();
      pulse_start(1'b0, 32'h0);
      for (int k = 0; k <= 4; k++) step();
      n_tests++;
      if (nrn_x !== exp_vec[4]) begin
         n_fail++;
         $display("FAIL mid_k4: nrn_x got %h want %h", nrn_x, exp_vec[4]);
      end
      rst = 1'b0;
      step();
      rst = 1'b1;
      n_tests++;
      if ({busy, nrn_rst, nrn_x, res_valid} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_abort: busy %b nrn_rst %b nrn_x %h res_valid %b want 0 1 0 0", busy, nrn_rst, nrn_x, res_valid);
      end
      for (int i = 0; i < N; i++) exp_vec[i] = 32'h0;
      stub_out = 32'h3DCCCCCD;
      step();
      pulse_start(1'b0, 32'h0);
      do_stream("mid", -1);
      finish_run("mid", 32'h3DCCCCCD, 1'b0);
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_timeout();
      test_ignore_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
